// File: rtl/netlist_vector_sequencer_if.sv
// Host/netlist bundle for netlist_vector_sequencer: run control and signature
// reporting on the host side, stimulus vector and response on the netlist side.
interface netlist_vector_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_patterns;
    logic [13:0]      seed;
    logic [15:0]      golden;
    logic [7:0]       resp_in;
    logic [13:0]      vec_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      signature;
    logic [CNT_W-1:0] patt_cnt;

    modport master (
        output start, abort, num_patterns, seed, golden, resp_in,
        input  vec_out, busy, done, pass, signature, patt_cnt
    );

    modport slave (
        input  start, abort, num_patterns, seed, golden, resp_in,
        output vec_out, busy, done, pass, signature, patt_cnt
    );
endinterface

// File: rtl/netlist_vector_sequencer.sv
// Drives LFSR vectors into a combinational netlist, holds each for a settle
// time, compacts the responses into a MISR and compares against a golden value.
module netlist_vector_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    netlist_vector_sequencer_if.slave bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    settle_cnt;
    logic [CNT_W-1:0] target;
    logic [13:0]      vec_q;
    logic [15:0]      sig_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pass_q;

    logic [15:0]      sig_nxt;
    logic [13:0]      vec_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [13:0]      seed_eff;
    logic             last_capture;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    always_comb begin
        sig_nxt      = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]}
                       ^ {8'h00, bus.resp_in};
        vec_nxt      = {vec_q[12:0], vec_q[13] ^ vec_q[12] ^ vec_q[11] ^ vec_q[1]};
        cnt_inc      = cnt_q + CNT_W'(1);
        last_capture = (cnt_inc == target);
        seed_eff     = (bus.seed == 14'h0000) ? 14'h0001 : bus.seed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.num_patterns == '0) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (settle_cnt == '0) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (last_capture) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SETTLE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state == S_SETTLE) || (state == S_CAPTURE);
        bus.done      = (state == S_DONE);
        bus.vec_out   = vec_q;
        bus.signature = sig_q;
        bus.patt_cnt  = cnt_q;
        bus.pass      = pass_q;
    end

    // pass is resolved on the edge that enters DONE; abort leaves everything frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            target     <= '0;
            vec_q      <= 14'h0000;
            sig_q      <= 16'hFFFF;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        target     <= bus.num_patterns;
                        vec_q      <= seed_eff;
                        sig_q      <= 16'hFFFF;
                        cnt_q      <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        pass_q     <= (bus.num_patterns == '0) && (bus.golden == 16'hFFFF);
                    end
                end
                S_SETTLE: begin
                    if (!bus.abort && settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (!bus.abort) begin
                        sig_q      <= sig_nxt;
                        vec_q      <= vec_nxt;
                        cnt_q      <= cnt_inc;
                        settle_cnt <= SETTLE_LOAD;
                        if (last_capture) begin
                            pass_q <= (sig_nxt == bus.golden);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_netlist_vector_sequencer.sv
// Randomized self-checking bench for netlist_vector_sequencer against a
// pattern-level reference model of the LFSR/MISR run.
module tb_netlist_vector_sequencer;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    netlist_vector_sequencer_if #(.CNT_W(CNT_W)) bus();

    netlist_vector_sequencer #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    logic        resp_mode;
    logic [7:0]  resp_const;
    logic [7:0]  tbl [256];
    logic [13:0] trace [$];

    // Stand-in for the netlist under test: an arbitrary combinational function of vec_out.
    function automatic logic [7:0] netlist_fn(input logic [13:0] v);
        return tbl[v[7:0]] ^ {v[13:8], 2'b00};
    endfunction

    assign bus.resp_in = resp_mode ? netlist_fn(bus.vec_out) : resp_const;

    function automatic logic [13:0] lfsr_step(input logic [13:0] v);
        return {v[12:0], ^(v & 14'h3802)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
        return {s[14:0], ^(s & 16'hD008)} ^ {8'h00, r};
    endfunction

    function automatic logic [13:0] eff_seed(input logic [13:0] s);
        return (s == 14'h0000) ? 14'h0001 : s;
    endfunction

    function automatic logic [15:0] model_sig(input logic [13:0] s, input int n);
        logic [13:0] v;
        logic [15:0] sig;
        v   = eff_seed(s);
        sig = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            sig = misr_step(sig, resp_mode ? netlist_fn(v) : resp_const);
            v   = lfsr_step(v);
        end
        return sig;
    endfunction

    // Waits for an idle cycle, then presents start across exactly one rising edge.
    task automatic start_run(input logic [CNT_W-1:0] n, input logic [13:0] s, input logic [15:0] g);
        @(negedge clk);
        for (int i = 0; i < BUDGET && (bus.busy || bus.done); i++) @(negedge clk);
        bus.start        = 1'b1;
        bus.num_patterns = n;
        bus.seed         = s;
        bus.golden       = g;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts rising edges from the start edge until done is seen, recording vec_out.
    task automatic wait_done(output int k, output bit seen);
        trace.delete();
        k    = 0;
        seen = bus.done;
        trace.push_back(bus.vec_out);
        while (!seen && k < BUDGET) begin
            @(posedge clk);
            #1;
            k++;
            seen = bus.done;
            trace.push_back(bus.vec_out);
        end
    endtask

    task automatic test_reset();
        logic [13:0] s;
        int k;
        bit seen;
        rst = 1'b1;
        #12;
        checks++; if (bus.vec_out !== 14'h0)     $display("[TB] FAIL reset_vec: got %h expected 0000", bus.vec_out);     else passes++;
        checks++; if (bus.signature !== 16'hFFFF) $display("[TB] FAIL reset_sig: got %h expected ffff", bus.signature); else passes++;
        checks++; if (bus.patt_cnt !== '0)       $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.patt_cnt);     else passes++;
        checks++; if ({bus.pass, bus.done, bus.busy} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {bus.pass, bus.done, bus.busy}); else passes++;
        @(negedge clk);
        rst = 1'b0;
        s = 14'($urandom) | 14'h0100;
        start_run(16'd4, s, 16'h0000);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.vec_out !== 14'h0 || bus.signature !== 16'hFFFF || bus.patt_cnt !== '0 || bus.busy !== 1'b0)
            $display("[TB] FAIL reset_midrun: got vec=%h sig=%h cnt=%0d busy=%b expected 0000/ffff/0/0",
                     bus.vec_out, bus.signature, bus.patt_cnt, bus.busy);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        s = 14'($urandom);
        start_run(16'd1, s, 16'h0000);
        checks++; if (bus.busy !== 1'b1 || bus.vec_out !== eff_seed(s))
            $display("[TB] FAIL start_after_reset: got busy=%b vec=%h expected 1/%h", bus.busy, bus.vec_out, eff_seed(s));
        else passes++;
        wait_done(k, seen);
        checks++; if (!seen || bus.signature !== model_sig(s, 1))
            $display("[TB] FAIL run_after_reset: got done=%b sig=%h expected 1/%h", seen, bus.signature, model_sig(s, 1));
        else passes++;
    endtask

    task automatic test_lfsr_seed();
        int k;
        bit seen;
        resp_mode = 1'b1;
        start_run(16'd3, 14'h0000, 16'h0000);
        wait_done(k, seen);
        checks++; if (!seen || k != 3 * (SETTLE + 1))
            $display("[TB] FAIL lfsr_done_time: got done=%b edges=%0d expected 1/%0d", seen, k, 3 * (SETTLE + 1));
        else passes++;
        checks++; if (trace.size() < 7 || trace[0] !== 14'h0001 || trace[3] !== 14'h0002 || trace[6] !== 14'h0005)
            $display("[TB] FAIL lfsr_sequence: got %h %h %h expected 0001 0002 0005",
                     trace[0], trace[3 % trace.size()], trace[6 % trace.size()]);
        else passes++;
        checks++; if (bus.patt_cnt !== 16'd3) $display("[TB] FAIL lfsr_cnt: got %0d expected 3", bus.patt_cnt); else passes++;
        checks++; if (bus.signature !== model_sig(14'h0000, 3))
            $display("[TB] FAIL lfsr_sig: got %h expected %h", bus.signature, model_sig(14'h0000, 3));
        else passes++;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL busy_at_done: got %b expected 0", bus.busy); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) $display("[TB] FAIL done_pulse_width: got %b expected 0", bus.done); else passes++;
    endtask

    task automatic test_misr_zero();
        int k;
        bit seen;
        resp_mode  = 1'b0;
        resp_const = 8'h00;
        start_run(16'd1, 14'($urandom), 16'h0000);
        wait_done(k, seen);
        checks++; if (!seen || bus.signature !== 16'hFFFE) $display("[TB] FAIL misr_zero_n1: got %h expected fffe", bus.signature); else passes++;
        start_run(16'd2, 14'($urandom), 16'hFFFC);
        wait_done(k, seen);
        checks++; if (!seen || bus.signature !== 16'hFFFC || bus.pass !== 1'b1)
            $display("[TB] FAIL misr_zero_n2_pass: got sig=%h pass=%b expected fffc/1", bus.signature, bus.pass);
        else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.pass !== 1'b1) $display("[TB] FAIL pass_hold: got %b expected 1", bus.pass); else passes++;
        start_run(16'd2, 14'($urandom), 16'hFFFD);
        wait_done(k, seen);
        checks++; if (!seen || bus.pass !== 1'b0) $display("[TB] FAIL misr_zero_n2_fail: got pass=%b expected 0", bus.pass); else passes++;
    endtask

    task automatic test_misr_nonzero();
        int k;
        bit seen;
        resp_mode  = 1'b0;
        resp_const = 8'hA5;
        start_run(16'd1, 14'($urandom), 16'hFF5B);
        wait_done(k, seen);
        checks++; if (!seen || bus.signature !== 16'hFF5B || bus.pass !== 1'b1)
            $display("[TB] FAIL misr_a5: got sig=%h pass=%b expected ff5b/1", bus.signature, bus.pass);
        else passes++;
    endtask

    task automatic test_zero_count();
        int k;
        bit seen;
        logic [13:0] s;
        s = 14'($urandom) | 14'h0001;
        start_run(16'd0, s, 16'hFFFF);
        wait_done(k, seen);
        checks++; if (!seen || k != 0) $display("[TB] FAIL zero_done_time: got done=%b edges=%0d expected 1/0", seen, k); else passes++;
        checks++; if (bus.pass !== 1'b1 || bus.vec_out !== s || bus.signature !== 16'hFFFF)
            $display("[TB] FAIL zero_result: got pass=%b vec=%h sig=%h expected 1/%h/ffff", bus.pass, bus.vec_out, bus.signature, s);
        else passes++;
        start_run(16'd0, s, 16'h1234);
        wait_done(k, seen);
        checks++; if (!seen || bus.pass !== 1'b0) $display("[TB] FAIL zero_mismatch_pass: got %b expected 0", bus.pass); else passes++;
    endtask

    task automatic test_abort();
        logic [13:0] s;
        int n_done;
        s         = 14'($urandom);
        resp_mode = 1'b1;
        start_run(16'd5, s, model_sig(s, 5));
        repeat (2 * (SETTLE + 1) - 1) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0)
            $display("[TB] FAIL abort_flags: got busy=%b done=%b pass=%b expected 0/0/0", bus.busy, bus.done, bus.pass);
        else passes++;
        checks++; if (bus.patt_cnt !== 16'd1 || bus.signature !== model_sig(s, 1) || bus.vec_out !== lfsr_step(eff_seed(s)))
            $display("[TB] FAIL abort_frozen: got cnt=%0d sig=%h vec=%h expected 1/%h/%h",
                     bus.patt_cnt, bus.signature, bus.vec_out, model_sig(s, 1), lfsr_step(eff_seed(s)));
        else passes++;
        n_done = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        checks++; if (n_done != 0 || bus.patt_cnt !== 16'd1)
            $display("[TB] FAIL abort_idle: got dones=%0d cnt=%0d expected 0/1", n_done, bus.patt_cnt);
        else passes++;
    endtask

    task automatic test_start_ignored();
        logic [13:0] s;
        int k;
        bit seen;
        s         = 14'($urandom);
        resp_mode = 1'b1;
        start_run(16'd3, s, model_sig(s, 3));
        repeat (4) @(posedge clk);
        #1;
        bus.start        = 1'b1;
        bus.num_patterns = 16'd1;
        bus.seed         = ~s;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.num_patterns = 16'd3;
        bus.seed         = s;
        wait_done(k, seen);
        checks++; if (!seen || k != 3 * (SETTLE + 1) - 5)
            $display("[TB] FAIL ignored_start_time: got done=%b edges=%0d expected 1/%0d", seen, k, 3 * (SETTLE + 1) - 5);
        else passes++;
        checks++; if (bus.patt_cnt !== 16'd3 || bus.signature !== model_sig(s, 3) || bus.pass !== 1'b1)
            $display("[TB] FAIL ignored_start_result: got cnt=%0d sig=%h pass=%b expected 3/%h/1",
                     bus.patt_cnt, bus.signature, bus.pass, model_sig(s, 3));
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] s;
        logic [15:0] exp_sig;
        logic [15:0] g;
        int n;
        int k;
        bit seen;
        bit want_pass;
        resp_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            n         = int'($urandom_range(1, 12));
            s         = 14'($urandom);
            exp_sig   = model_sig(s, n);
            want_pass = 1'($urandom);
            g         = want_pass ? exp_sig : exp_sig ^ (16'h0001 << $urandom_range(0, 15));
            start_run(CNT_W'(n), s, g);
            wait_done(k, seen);
            checks++; if (!seen || k != n * (SETTLE + 1))
                $display("[TB] FAIL b2b_time[%0d]: got done=%b edges=%0d expected 1/%0d", r, seen, k, n * (SETTLE + 1));
            else passes++;
            checks++; if (bus.signature !== exp_sig || bus.patt_cnt !== CNT_W'(n) || bus.pass !== want_pass)
                $display("[TB] FAIL b2b_result[%0d]: got sig=%h cnt=%0d pass=%b expected %h/%0d/%b",
                         r, bus.signature, bus.patt_cnt, bus.pass, exp_sig, n, want_pass);
            else passes++;
        end
        exp_sig = bus.signature;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.signature !== exp_sig || bus.busy !== 1'b0)
            $display("[TB] FAIL idle_hold: got sig=%h busy=%b expected %h/0", bus.signature, bus.busy, exp_sig);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
        resp_mode        = 1'b0;
        resp_const       = 8'h00;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.num_patterns = '0;
        bus.seed         = 14'h0;
        bus.golden       = 16'h0;
        test_reset();
        test_lfsr_seed();
        test_misr_zero();
        test_misr_nonzero();
        test_zero_count();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
